instr_encoder: RTL and testbench
================================

# instr_encoder

Encoding counterpart of the main control decoder. Accepts symbolic instruction requests (instruction class, register indices, funct bits, immediate) over a valid/ready handshake. Packs each request into a 32-bit RV32I word in the format the processor decodes (lw, sw, R-type, beq, I-type ALU, jal). Emits each word through a small output FIFO, paired with a sequential instruction-memory byte address. Used by the bench and program loader to write instruction memory.

## Interface
- DEPTH, 4: output FIFO entries; power of two, ≥2.
- ADDR_W, 8: width of out_addr (byte address).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  encoder can accept; equals FIFO not full.
- in_kind  in  3  0=lw, 1=sw, 2=R-type, 3=beq, 4=I-type ALU, 5=jal, 6/7 illegal.
- in_funct3  in  3  funct3 for R-type and I-type ALU; ignored otherwise.
- in_funct7b5  in  1  funct7[5] for R-type and I-type shifts.
- in_rd, in_rs1, in_rs2  in  5 each  register indices; unused fields ignored.
- in_imm  in  32  signed immediate, byte offset for beq/jal.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- out_instr  out  32  encoded word at FIFO head.
- out_addr  out  ADDR_W  byte address for out_instr.
- err  out  1  sticky: a request was rejected.
- err_cnt  out  8  count of rejected requests, saturates at 255.

## Operation
- Accept on in_valid && in_ready. Encode combinationally, then push into FIFO the same edge.
- Encodings, opcode in [6:0]:
  - lw: imm[11:0], rs1, f3=010, rd, 0000011.
  - sw: imm[11:5], rs2, rs1, 010, imm[4:0], 0100011.
  - R: {0,funct7b5,00000}, rs2, rs1, funct3, rd, 0110011.
  - beq: imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011.
  - I-ALU: imm[11:0], rs1, funct3, rd, 0010011. When funct3 is 001 or 101, bits [31:25]={0,funct7b5,00000} and [24:20]=imm[4:0].
  - jal: imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111.
- Illegal kind (6/7): accepted (handshake completes), not pushed, err set, err_cnt+1.
- out_addr:
  - Address counter resets to 0.
  - Each word enters the FIFO tagged with the counter value; the counter then advances by 4.
  - Wraps modulo 2^ADDR_W. Bits [1:0] are always 0.
  - Rejected requests do not advance the counter.
- FIFO:
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are allowed when not full. When full, in_ready=0 regardless of out_ready; no bypass.
- err is cleared only by reset.

## Timing
- Reset values: out_valid=0, in_ready=1, out_instr=0, out_addr=0, err=0, err_cnt=0. FIFO is empty; read/write pointers and address counter are 0.
- Latency: a request accepted at edge N is visible at the FIFO head after edge N (out_valid high in cycle N+1) if the FIFO was empty.
- out_instr and out_addr are stable while out_valid && !out_ready.
- in_ready depends only on registered occupancy; no combinational path from out_ready.
- Throughput: 1 word/cycle with out_ready held high.
- Asserting rst_n low mid-stream immediately discards FIFO contents and returns all outputs to reset values. No partial handshake survives.

## Configuration
- IMM_RANGE_CHECK_EN defined:
  - lw/sw/I-ALU require imm in −2048..2047.
  - Shifts require imm in 0..31.
  - beq requires imm in −4096..4094 and even.
  - jal requires imm in −1048576..1048574 and even.
  - A violation is treated as illegal: accepted, dropped, err set, err_cnt+1.
- Undefined: no checking. Immediates are silently truncated to the field bits; imm[0] is ignored for beq/jal.

## Test plan
- After reset, send addi x1,x0,5 (kind 4, f3 000, rd 1, rs1 0, imm 5) -> out_instr=0x00500093, out_addr=0x00 one cycle after accept.
- Back-to-back, out_ready=1:
  - lw x6,-4(x9) -> 0xFFC4A303 @0x04.
  - sw x6,8(x9) -> 0x0064A423 @0x08.
  - add x2,x3,x4 -> 0x00418133 @0x0C.
  - sub x2,x3,x4 -> 0x40418133 @0x10.
- beq x4,x4,16 -> 0x00420863. jal x1,8 -> 0x008000EF. Both with correct consecutive addresses.
- out_ready=0, send 5 requests:
  - in_ready drops after the 4th accept (DEPTH=4) and the 5th waits.
  - Then pulse out_ready once: in_ready rises the next cycle and words drain in order.
- Illegal cases:
  - kind 7 -> err=1, err_cnt=1, no word emitted, next legal word takes the unadvanced address.
  - With IMM_RANGE_CHECK_EN, addi imm 2048 -> err_cnt=2.
- Stream 70 words with ADDR_W=8 -> out_addr goes 0xFC -> 0x00. Then assert rst_n low with 3 words queued -> out_valid=0 immediately, and the next word after release is at 0x00.

Source files
------------

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs symbolic requests into RV32I words, queued with byte addresses
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [2:0] KIND_LW   = 3'd0;
  localparam logic [2:0] KIND_SW   = 3'd1;
  localparam logic [2:0] KIND_R    = 3'd2;
  localparam logic [2:0] KIND_BEQ  = 3'd3;
  localparam logic [2:0] KIND_IALU = 3'd4;
  localparam logic [2:0] KIND_JAL  = 3'd5;

  logic [31:0]       fifo_instr_q [DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q  [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [31:0] instr_enc;
  logic        legal;
  logic        is_shift;
  logic        accept, push, pop, reject;
  logic        unused_imm_hi;

  assign unused_imm_hi = ^in_imm[31:21];
  assign is_shift      = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  always_comb begin
    instr_enc = '0;
    legal     = 1'b1;
    case (in_kind)
      KIND_LW:  instr_enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      KIND_SW:  instr_enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      KIND_R:   instr_enc = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd,
                             7'b0110011};
      KIND_BEQ: instr_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000, in_imm[4:1],
                             in_imm[11], 7'b1100011};
      KIND_IALU: begin
        if (is_shift) begin
          instr_enc = {1'b0, in_funct7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd,
                       7'b0010011};
        end else begin
          instr_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        end
      end
      KIND_JAL: instr_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd,
                             7'b1101111};
      default:  legal = 1'b0;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    // Out-of-range immediates are rejected the same way as illegal kinds.
    case (in_kind)
      KIND_LW, KIND_SW:
        legal = ($signed(in_imm) >= -32'sd2048) && ($signed(in_imm) <= 32'sd2047);
      KIND_IALU:
        if (is_shift) legal = ($signed(in_imm) >= 32'sd0) && ($signed(in_imm) <= 32'sd31);
        else legal = ($signed(in_imm) >= -32'sd2048) && ($signed(in_imm) <= 32'sd2047);
      KIND_BEQ:
        legal = ($signed(in_imm) >= -32'sd4096) && ($signed(in_imm) <= 32'sd4094) && !in_imm[0];
      KIND_JAL:
        legal = ($signed(in_imm) >= -32'sd1048576) && ($signed(in_imm) <= 32'sd1048574)
                && !in_imm[0];
      default: ;
    endcase
`endif
  end

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign reject    = accept && !legal;
  assign pop       = out_valid && out_ready;

  // Gate the head so an empty queue shows zeros rather than stale entries.
  assign out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign out_addr  = out_valid ? fifo_addr_q[rd_ptr_q]  : '0;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    addr_d    = addr_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      addr_d   = addr_q + ADDR_W'(4);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    if (reject) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_addr_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      if (push) begin
        fifo_instr_q[wr_ptr_q] <= instr_enc;
        fifo_addr_q[wr_ptr_q]  <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized bench for instr_encoder against a behavioural model
module tb_instr_encoder;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_kind = '0;
  logic [2:0]        in_funct3 = '0;
  logic              in_funct7b5 = 1'b0;
  logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0]       in_imm = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic [7:0]        err_cnt;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: field placement by arithmetic shifts of the raw immediate.
  function automatic int unsigned ref_word(int kind, int f3, int f7, int rd, int rs1, int rs2,
                                           int imm);
    int unsigned u;
    int unsigned base;
    u    = imm;
    base = (rs1 << 15) | (rd << 7);
    case (kind)
      0: return ((u & 32'hFFF) << 20) | base | (2 << 12) | 32'h03;
      1: return (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                | ((u & 31) << 7) | 32'h23;
      2: return (f7 * 32'h4000_0000) | (rs2 << 20) | base | (f3 << 12) | 32'h33;
      3: return (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
                | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      4: if (f3 == 1 || f3 == 5)
           return (f7 * 32'h4000_0000) | ((u & 31) << 20) | base | (f3 << 12) | 32'h13;
         else
           return ((u & 32'hFFF) << 20) | base | (f3 << 12) | 32'h13;
      default: return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                      | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12)
                      | (rd << 7) | 32'h6F;
    endcase
  endfunction

  function automatic bit ref_legal(int kind, int f3, int imm);
    if (kind > 5) return 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    case (kind)
      0, 1: return imm >= -2048 && imm <= 2047;
      4:    if (f3 == 1 || f3 == 5) return imm >= 0 && imm <= 31;
            else return imm >= -2048 && imm <= 2047;
      3:    return imm >= -4096 && imm <= 4094 && (imm % 2) == 0;
      5:    return imm >= -1048576 && imm <= 1048574 && (imm % 2) == 0;
      default: return 1'b1;
    endcase
`else
    return 1'b1;
`endif
  endfunction

  typedef struct { logic [31:0] instr; logic [7:0] addr; } word_t;
  word_t exp_q[$];
  int    model_addr = 0;
  int    model_err = 0;
  int    model_err_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      model_addr = 0;
      model_err = 0;
      model_err_cnt = 0;
    end else begin
      bit was_full;
      word_t w;
      was_full = (exp_q.size() == DEPTH);
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready, !was_full);
      check("err", err, model_err);
      check("err_cnt", err_cnt, model_err_cnt);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("out_instr", out_instr, w.instr);
        check("out_addr", out_addr, w.addr);
      end
      if (in_valid && !was_full) begin
        if (ref_legal(in_kind, in_funct3, int'(in_imm))) begin
          w.instr = ref_word(in_kind, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2,
                             int'(in_imm));
          w.addr  = model_addr[7:0];
          exp_q.push_back(w);
          model_addr = (model_addr + 4) % 256;
        end else begin
          model_err = 1;
          if (model_err_cnt < 255) model_err_cnt++;
        end
      end
    end
  end

  bit rand_ready = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input int k, input int f3, input int f7, input int rd, input int rs1,
                      input int rs2, input int imm);
    int waited = 0;
    in_kind = 3'(k); in_funct3 = 3'(f3); in_funct7b5 = f7[0];
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] instr, input logic [7:0] addr);
    @(negedge clk);
    check({tag, "_instr"}, out_instr, instr);
    check({tag, "_addr"}, out_addr, addr);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int waited = 0;
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && waited < 100) begin
      waited++;
      @(posedge clk);
      #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic send_random();
    int k, f3, r, imm;
    k  = $urandom_range(0, 15);
    k  = (k >= 14) ? k - 8 : k % 6;
    f3 = $urandom_range(0, 7);
    case (k)
      3: begin r = $urandom_range(0, 8191); imm = (r - 4096) & ~1; end
      5: begin r = $urandom_range(0, 2097151); imm = (r - 1048576) & ~1; end
      4: if (f3 == 1 || f3 == 5) imm = $urandom_range(0, 31);
         else begin r = $urandom_range(0, 4095); imm = r - 2048; end
      default: begin r = $urandom_range(0, 4095); imm = r - 2048; end
    endcase
    if ($urandom_range(0, 9) == 0) imm = $urandom();
    send(k, f3, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 31), imm);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_addr", out_addr, 32'h0);
    check("rst_err", err, 1'b0);
    check("rst_err_cnt", err_cnt, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    send(4, 0, 0, 1, 0, 0, 5);    expect_head("addi", 32'h00500093, 8'h00);
    send(0, 0, 0, 6, 9, 0, -4);   expect_head("lw",   32'hFFC4A303, 8'h04);
    send(1, 0, 0, 0, 9, 6, 8);    expect_head("sw",   32'h0064A423, 8'h08);
    send(2, 0, 0, 2, 3, 4, 0);    expect_head("add",  32'h00418133, 8'h0C);
    send(2, 0, 1, 2, 3, 4, 0);    expect_head("sub",  32'h40418133, 8'h10);
    send(3, 0, 0, 0, 4, 4, 16);   expect_head("beq",  32'h00420863, 8'h14);
    send(5, 0, 0, 1, 0, 0, 8);    expect_head("jal",  32'h008000EF, 8'h18);

    send(7, 0, 0, 1, 0, 0, 5);
    @(negedge clk);
    check("illegal_err", err, 1'b1);
    check("illegal_err_cnt", err_cnt, 32'd1);
    check("illegal_no_word", out_valid, 1'b0);
    @(posedge clk);
    #1;
    send(4, 0, 0, 1, 0, 0, 5);    expect_head("after_illegal", 32'h00500093, 8'h1C);

    send(4, 0, 0, 1, 0, 0, 2048);
    @(negedge clk);
`ifdef IMM_RANGE_CHECK_EN
    check("range_err_cnt", err_cnt, 32'd2);
`else
    check("range_err_cnt", err_cnt, 32'd1);
    check("trunc_instr", out_instr, 32'h80000093);
`endif
    @(posedge clk);
    #1;
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4, 0, 0, i + 1, 0, 0, i);
    @(negedge clk);
    check("full_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    in_kind = 3'd4; in_funct3 = 3'd0; in_rd = 5'd9; in_rs1 = 5'd0; in_imm = 32'd9;
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("fifth_waits", in_ready, 1'b0);
      if (exp_q.size() != 0) check("hold_instr", out_instr, exp_q[0].instr);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("ready_after_pulse", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    for (int i = 0; i < 260; i++) send(6, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("err_cnt_sat", err_cnt, 32'd255);
    @(posedge clk);
    #1;

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      send_random();
    end
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(2, 0, 0, 5, 6, 7, 0);
    @(negedge clk);
    check("queued_before_rst", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_instr", out_instr, 32'h0);
    check("mid_rst_out_addr", out_addr, 32'h0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_err_cnt", err_cnt, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(4, 0, 0, 1, 0, 0, 5);    expect_head("post_rst", 32'h00500093, 8'h00);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
